// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and constants for the serial magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10
    } cmp_rel_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } cmp_state_t;

    localparam int DIGIT_W = 2;

    // An unequal digit decides the relation; an equal digit keeps what the lower digits decided.
    function automatic cmp_rel_t merge_rel(input cmp_rel_t base, input logic gt, input logic lt);
        cmp_rel_t r;
        r = base;
        if (gt) begin
            r = CMP_GT;
        end else if (lt) begin
            r = CMP_LT;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_compare_2bit.sv
// rtl/digit_compare_2bit.sv - combinational greater/less compare of one digit pair
module digit_compare_2bit
    import cmp_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               gt,
    output logic               lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - LSB-digit-first serial unsigned comparator with handshaked verdict
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic [DIGIT_W-1:0] digit_a,
    input  logic [DIGIT_W-1:0] digit_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               greater,
    output logic               less,
    output logic               equal
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    cmp_state_t       state_q, state_d;
    cmp_rel_t         rel_q, rel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_valid_q, res_valid_d;
    logic             greater_q, greater_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;

    logic             dig_gt;
    logic             dig_lt;
    logic             accept;
    cmp_rel_t         base_rel;
    cmp_rel_t         dig_rel;

    digit_compare_2bit u_digit_cmp (
        .a  (digit_a),
        .b  (digit_b),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    assign digit_ready = (state_q == ST_RUN);
    assign accept      = digit_valid & digit_ready;

    // Digit 0 always starts from EQ so no earlier operand can leak into this one.
    assign base_rel = (cnt_q == '0) ? CMP_EQ : rel_q;
    assign dig_rel  = merge_rel(base_rel, dig_gt, dig_lt);

    always_comb begin
        state_d     = state_q;
        rel_d       = rel_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        greater_d   = greater_q;
        less_d      = less_q;
        equal_d     = equal_q;

        if (abort) begin
            state_d     = ST_RUN;
            rel_d       = CMP_EQ;
            cnt_d       = '0;
            res_valid_d = 1'b0;
            greater_d   = 1'b0;
            less_d      = 1'b0;
            equal_d     = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (accept) begin
                rel_d = dig_rel;
                if (cnt_q == LAST_DIG) begin
                    state_d     = ST_DONE;
                    cnt_d       = '0;
                    res_valid_d = 1'b1;
                    greater_d   = (dig_rel == CMP_GT);
                    less_d      = (dig_rel == CMP_LT);
                    equal_d     = (dig_rel == CMP_EQ);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            if (res_valid_q && res_ready) begin
                state_d     = ST_RUN;
                rel_d       = CMP_EQ;
                res_valid_d = 1'b0;
                greater_d   = 1'b0;
                less_d      = 1'b0;
                equal_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            rel_q       <= CMP_EQ;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            greater_q   <= 1'b0;
            less_q      <= 1'b0;
            equal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rel_q       <= rel_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            greater_q   <= greater_d;
            less_q      <= less_d;
            equal_q     <= equal_d;
        end
    end

    assign res_valid = res_valid_q;
    assign greater   = greater_q;
    assign less      = less_q;
    assign equal     = equal_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - scoreboard bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;

    logic       clk;
    logic       rst_n;
    logic       abort;
    logic       digit_valid;
    logic       digit_ready;
    logic [1:0] digit_a;
    logic [1:0] digit_b;
    logic       res_valid;
    logic       res_ready;
    logic       greater;
    logic       less;
    logic       equal;

    int total = 0;
    int bad   = 0;

    // expected verdicts as {greater, less, equal}
    logic [2:0] sb[$];

    localparam logic [2:0] V_GT = 3'b100;
    localparam logic [2:0] V_LT = 3'b010;
    localparam logic [2:0] V_EQ = 3'b001;

    serial_magnitude_comparator #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .abort       (abort),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit_a     (digit_a),
        .digit_b     (digit_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .greater     (greater),
        .less        (less),
        .equal       (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: settles 1 time unit after the falling edge so driver updates are visible.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (res_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_verdict", {29'd0, greater, less, equal}, 32'd0);
                end else begin
                    check("verdict", {29'd0, greater, less, equal}, {29'd0, sb[0]});
                    if (res_ready || abort) void'(sb.pop_front());
                end
            end else begin
                check("idle_flags", {29'd0, greater, less, equal}, 32'd0);
            end
        end
    end

    task automatic drive_digit(input logic [1:0] a, input logic [1:0] b);
        int n;
        n = 0;
        digit_valid = 1'b1;
        digit_a     = a;
        digit_b     = b;
        while (!digit_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!digit_ready) check("digit_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] exp);
        sb.push_back(exp);
        for (int i = 0; i < 4; i++) begin
            drive_digit(a[2*i +: 2], b[2*i +: 2]);
            if (i < 3) check("early_verdict", {31'd0, res_valid}, 32'd0);
        end
        digit_valid = 1'b0;
        check("latency", {31'd0, res_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        abort       = 1'b0;
        digit_valid = 1'b0;
        digit_a     = 2'b00;
        digit_b     = 2'b00;
        res_ready   = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_res_valid", {31'd0, res_valid}, 32'd0);
        check("reset_flags", {29'd0, greater, less, equal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_digit_ready", {31'd0, digit_ready}, 32'd1);

        // 0xB4 vs 0x74: top digit decides greater
        send_op(8'hB4, 8'h74, V_GT);
        check("t1_greater", {31'd0, greater}, 32'd1);
        check("t1_ready_low", {31'd0, digit_ready}, 32'd0);
        @(negedge clk);
        check("t1_one_cycle", {31'd0, res_valid}, 32'd0);

        // equal upper digits keep the LSB decision, then relation restarts for the next operand
        send_op(8'h41, 8'h42, V_LT);
        check("t2_less", {31'd0, less}, 32'd1);
        send_op(8'h5A, 8'h5A, V_EQ);
        check("t2_equal", {31'd0, equal}, 32'd1);
        @(negedge clk);

        // backpressure: verdict held, new valid data ignored
        res_ready = 1'b0;
        send_op(8'h80, 8'h7F, V_GT);
        digit_valid = 1'b1;
        digit_a     = 2'b01;
        digit_b     = 2'b10;
        for (int i = 0; i < 4; i++) begin
            check("bp_res_valid", {31'd0, res_valid}, 32'd1);
            check("bp_greater", {31'd0, greater}, 32'd1);
            check("bp_ready_low", {31'd0, digit_ready}, 32'd0);
            if (i == 3) res_ready = 1'b1;
            @(negedge clk);
        end
        check("bp_released", {31'd0, res_valid}, 32'd0);
        send_op(8'h01, 8'h02, V_LT);
        @(negedge clk);

        // asynchronous reset mid-operand
        drive_digit(2'b11, 2'b00);
        drive_digit(2'b11, 2'b00);
        digit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_mid_flags", {29'd0, greater, less, equal}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send_op(8'h03, 8'h0C, V_LT);
        @(negedge clk);

        // abort together with the final digit drops it
        drive_digit(2'b00, 2'b00);
        drive_digit(2'b00, 2'b00);
        drive_digit(2'b00, 2'b00);
        digit_valid = 1'b1;
        digit_a     = 2'b11;
        digit_b     = 2'b00;
        abort       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort       = 1'b0;
        digit_valid = 1'b0;
        check("abort_no_verdict", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("abort_no_verdict2", {31'd0, res_valid}, 32'd0);
        send_op(8'h01, 8'h01, V_EQ);
        @(negedge clk);

        // abort while holding a verdict
        res_ready = 1'b0;
        send_op(8'h05, 8'h06, V_LT);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done_valid", {31'd0, res_valid}, 32'd0);
        check("abort_done_ready", {31'd0, digit_ready}, 32'd1);
        res_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
